// File: rtl/ekf_ch_pkg.sv
// rtl/ekf_ch_pkg.sv - shared sequencer state encoding and default widths for the EKF charge path
package ekf_ch_pkg;

    // Default ROM sample word width, ROM address width and sweep length
    localparam int CH_D_WIDTH   = 16;
    localparam int CH_A_WIDTH   = 10;
    localparam int CH_N_SAMPLES = 1024;

    // Sequencer states: fetch address, wait for the registered ROM data,
    // present to the EKF core, then park in DONE after a one-shot sweep
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ADDR    = 3'd1,
        ST_WAIT    = 3'd2,
        ST_PRESENT = 3'd3,
        ST_DONE    = 3'd4
    } ch_state_e;

endpackage

// File: rtl/charge_sample_seq.sv
// rtl/charge_sample_seq.sv - sweeps the ib/vt/soc ROMs and presents samples to the EKF core (option: CHARGE_SEQ_LOOP_EN)
module charge_sample_seq
    import ekf_ch_pkg::*;
#(
    parameter int D_WIDTH   = CH_D_WIDTH,
    parameter int A_WIDTH   = CH_A_WIDTH,
    parameter int N_SAMPLES = CH_N_SAMPLES
) (
    input  logic               clk,
    input  logic               n_rst,
    input  logic               start,
    input  logic               abort,
    output logic [A_WIDTH-1:0] rom_raddr,
    input  logic [D_WIDTH-1:0] ib_in,
    input  logic [D_WIDTH-1:0] vt_in,
    input  logic [D_WIDTH-1:0] soc_in,
    output logic               s_valid,
    input  logic               s_ready,
    output logic [D_WIDTH-1:0] s_ib,
    output logic [D_WIDTH-1:0] s_vt,
    output logic [D_WIDTH-1:0] s_soc,
    output logic [A_WIDTH-1:0] s_idx,
    output logic               busy,
    output logic               done
);

    // Terminal index computed in A_WIDTH bits so a full 2**A_WIDTH sweep
    // compares against all-ones and the counter never has to overflow
    localparam logic [A_WIDTH-1:0] LAST_IDX = A_WIDTH'(N_SAMPLES - 1);

    ch_state_e          state_q;
    logic [A_WIDTH-1:0] cnt_q;
    logic [A_WIDTH-1:0] cnt_d;
    logic [A_WIDTH-1:0] raddr_q;
    logic [D_WIDTH-1:0] ib_q;
    logic [D_WIDTH-1:0] vt_q;
    logic [D_WIDTH-1:0] soc_q;
    logic [A_WIDTH-1:0] idx_q;
    logic               valid_q;
    logic               busy_q;
    logic               done_q;
    logic               is_last;

    // Next sample index and terminal-sample detect
    always_comb begin
        cnt_d   = cnt_q + A_WIDTH'(1);
        is_last = (cnt_q == LAST_IDX);
    end

    // Sequencer FSM; every output is a register updated alongside the state.
    // rom_raddr is loaded on entry to ADDR so the ROM registers it during
    // ADDR and its data is ready to be captured at the end of WAIT.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            raddr_q <= '0;
            ib_q    <= '0;
            vt_q    <= '0;
            soc_q   <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (abort) begin
                // Abort dominates start and any handshake; no done pulse
                state_q <= ST_IDLE;
                valid_q <= 1'b0;
                busy_q  <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE, ST_DONE: begin
                        if (start) begin
                            state_q <= ST_ADDR;
                            cnt_q   <= '0;
                            raddr_q <= '0;
                            busy_q  <= 1'b1;
                        end
                    end
                    ST_ADDR: begin
                        state_q <= ST_WAIT;
                    end
                    ST_WAIT: begin
                        ib_q    <= ib_in;
                        vt_q    <= vt_in;
                        soc_q   <= soc_in;
                        idx_q   <= cnt_q;
                        valid_q <= 1'b1;
                        state_q <= ST_PRESENT;
                    end
                    ST_PRESENT: begin
                        if (s_ready) begin
                            valid_q <= 1'b0;
                            if (is_last) begin
                                done_q <= 1'b1;
`ifdef CHARGE_SEQ_LOOP_EN
                                cnt_q   <= '0;
                                raddr_q <= '0;
                                state_q <= ST_ADDR;
`else
                                busy_q  <= 1'b0;
                                state_q <= ST_DONE;
`endif
                            end else begin
                                cnt_q   <= cnt_d;
                                raddr_q <= cnt_d;
                                state_q <= ST_ADDR;
                            end
                        end
                    end
                    default: begin
                        state_q <= ST_IDLE;
                        valid_q <= 1'b0;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign rom_raddr = raddr_q;
    assign s_valid   = valid_q;
    assign s_ib      = ib_q;
    assign s_vt      = vt_q;
    assign s_soc     = soc_q;
    assign s_idx     = idx_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: doc/charge_sample_seq.md
CHARGE_SAMPLE_SEQ -- requirements
Module: charge_sample_seq

Interface
REQ-001 The block SHALL have parameter D_WIDTH, default 16, the width of one ROM sample word.
REQ-002 The block SHALL have parameter A_WIDTH, default 10, the width of the ROM address.
REQ-003 The block SHALL have parameter N_SAMPLES, default 1024, the number of samples per sweep; legal range 1..2**A_WIDTH.
REQ-004 The block SHALL have port clk, input, 1 bit: the clock.
REQ-005 The block SHALL have port n_rst, input, 1 bit: the reset, asynchronous and active-low.
REQ-006 The block SHALL have port start, input, 1 bit: a pulse that begins a sweep.
REQ-007 The block SHALL have port abort, input, 1 bit: a pulse that terminates a sweep.
REQ-008 The block SHALL have port rom_raddr, output, A_WIDTH bits: the address shared by the ib, vt and soc ROMs.
REQ-009 The block SHALL have ports ib_in, vt_in and soc_in, inputs, D_WIDTH bits each: the ROM data_out values, registered one clock after rom_raddr.
REQ-010 The block SHALL have port s_valid, output, 1 bit: a sample is presented to the EKF core.
REQ-011 The block SHALL have port s_ready, input, 1 bit: the EKF core accepts the sample.
REQ-012 The block SHALL have ports s_ib, s_vt and s_soc, outputs, D_WIDTH bits each: the sample payload.
REQ-013 The block SHALL have port s_idx, output, A_WIDTH bits: the index of the sample presented.
REQ-014 The block SHALL have port busy, output, 1 bit: high in every state other than IDLE and DONE.
REQ-015 The block SHALL have port done, output, 1 bit: a one-cycle pulse on completion of a sweep.

Function
REQ-016 The block SHALL implement a finite state machine with states IDLE, ADDR, WAIT, PRESENT and DONE.
REQ-017 The FSM SHALL leave IDLE or DONE on start=1, going to ADDR with the address counter at 0.
REQ-018 In ADDR, the block SHALL drive rom_raddr to the counter value and then go to WAIT.
REQ-019 In WAIT, the block SHALL capture ib_in, vt_in and soc_in into s_ib, s_vt and s_soc, load s_idx from the counter, and go to PRESENT.
REQ-020 The first s_valid SHALL assert 3 cycles after the start edge.
REQ-021 rom_raddr SHALL hold its value from ADDR through WAIT.
REQ-022 In PRESENT, s_valid=1 and the payload SHALL be held stable until s_valid and s_ready are both high on a clock edge.
REQ-023 On a PRESENT handshake with counter < N_SAMPLES-1, the block SHALL increment the counter and go to ADDR; the steady-state throughput is one sample per 3 cycles.
REQ-024 On a PRESENT handshake with counter = N_SAMPLES-1, the block SHALL go to DONE and pulse done for one cycle, with behaviour per REQ-035 and REQ-036.
REQ-025 s_ready asserted outside PRESENT SHALL have no effect.
REQ-026 start while busy=1 SHALL be ignored.
REQ-027 abort in any state SHALL return the FSM to IDLE on the next edge, drop s_valid in the same edge, and not pulse done.
REQ-028 If abort and start arrive in the same cycle, abort SHALL win.
REQ-029 The counter SHALL be A_WIDTH bits wide; with N_SAMPLES = 2**A_WIDTH, the terminal compare SHALL use the value 2**A_WIDTH-1 and SHALL NOT overflow.
REQ-030 In DONE, outputs SHALL hold the last payload with s_valid=0 and busy=0.

Reset
REQ-031 On n_rst=0, the block SHALL asynchronously force state=IDLE, the counter, rom_raddr, s_ib, s_vt, s_soc and s_idx to 0, and s_valid, busy and done to 0.
REQ-032 Reset asserted during a sweep SHALL discard the sweep.
REQ-033 After reset, the block SHALL require a new start to begin a sweep.

Configuration
REQ-034 The feature macro SHALL be CHARGE_SEQ_LOOP_EN.
REQ-035 With CHARGE_SEQ_LOOP_EN defined, the last handshake SHALL pulse done, reset the counter to 0 and go to ADDR, so sweeps repeat continuously until abort.
REQ-036 Without CHARGE_SEQ_LOOP_EN, the last handshake SHALL go to DONE and stop.

Structure
REQ-037 The FSM state enum and the default widths SHALL live in the shared package ekf_ch_pkg.
REQ-038 The block SHALL contain no sub-module.
REQ-039 The three rom_charge instances (SELECT 0, 1 and 2) SHALL sit outside the block, in the parent.

Verification
REQ-040 Bench: N_SAMPLES=4, s_ready tied to 1, ROMs loaded with ib=addr -> s_idx sequence 0,1,2,3; first s_valid 3 cycles after start; done pulses once.
REQ-041 Bench: s_ready held low for 5 cycles at index 2 -> payload and s_idx=2 stable for all 5 cycles; rom_raddr unchanged.
REQ-042 Bench: abort pulsed in WAIT at index 1 -> next cycle state IDLE, s_valid=0, busy=0, done=0.
REQ-043 Bench: start pulsed at index 2 -> sequence unaffected; start after done -> new sweep from index 0.
REQ-044 Bench: n_rst pulsed low mid-PRESENT -> all outputs 0 immediately, asynchronously, without a clock edge.
REQ-045 Bench: CHARGE_SEQ_LOOP_EN with N_SAMPLES=2 -> indices 0,1,0,1 with a done pulse after each 1.
